// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: PC width, instruction size, default vectors
// and the fetch FSM state type used by pc_gen and pc_next_sel.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int ILEN_BYTES = 4;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: trap > redirect (aligned) > sequential step > hold.
// Build option COMPRESSED_EN: 2-byte alignment and +2 steps for 16-bit instructions.
module pc_next_sel #(
   parameter int              XLEN     = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] TRAP_VEC = rv_pkg::DEFAULT_TRAP_VEC
) (
   input  logic            enable,
   input  logic [XLEN-1:0] cur_pc,
   input  logic            trap_valid,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            accept,
   input  logic            fetch_is_rvc,
   output logic [XLEN-1:0] next_pc,
   output logic            misalign
);
   import rv_pkg::*;

`ifdef COMPRESSED_EN
   localparam int ALIGN_BITS = 1;
`else
   localparam int ALIGN_BITS = 2;
`endif

   localparam logic [XLEN-1:0] ALIGN_MASK =
      ~{{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};

   logic [XLEN-1:0] aligned_target;
   logic            target_misaligned;
   logic [XLEN-1:0] step;
   logic [XLEN-1:0] seq_pc;

   assign aligned_target    = redirect_pc & ALIGN_MASK;
   assign target_misaligned = |redirect_pc[ALIGN_BITS-1:0];

`ifdef COMPRESSED_EN
   assign step = fetch_is_rvc ? XLEN'(2) : XLEN'(ILEN_BYTES);
`else
   logic unused_rvc;
   assign unused_rvc = fetch_is_rvc;
   assign step       = XLEN'(ILEN_BYTES);
`endif

   // Plain modulo-2^XLEN add: the top of the address space wraps silently to zero.
   assign seq_pc = cur_pc + step;

   always_comb begin
      next_pc  = cur_pc;
      misalign = 1'b0;
      if (enable) begin
         if (trap_valid) begin
            next_pc = TRAP_VEC;
         end else if (redirect_valid) begin
            next_pc  = aligned_target;
            misalign = target_misaligned;
         end else if (accept) begin
            next_pc = seq_pc;
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the RV32I fetch stage: BOOT/RUN/HALT FSM, PC and
// sequence-tag registers, valid/ready fetch handshake. Build option: COMPRESSED_EN.
module pc_gen #(
   parameter int              XLEN      = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VEC = rv_pkg::DEFAULT_RESET_VEC,
   parameter logic [XLEN-1:0] TRAP_VEC  = rv_pkg::DEFAULT_TRAP_VEC,
   parameter int              SEQ_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             trap_valid,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             fetch_ready,
   input  logic             fetch_is_rvc,
   output logic             fetch_valid,
   output logic [XLEN-1:0]  fetch_pc,
   output logic [SEQ_W-1:0] fetch_seq,
   output logic             misalign_err,
   output logic             halted
);
   import rv_pkg::*;

   pc_state_e       state, state_next;
   logic            accept;
   logic            sel_enable;
   logic [XLEN-1:0] next_pc;
   logic            next_misalign;

   assign fetch_valid = (state == RUN);
   assign halted      = (state == HALT);
   assign accept      = fetch_valid & fetch_ready & ~stall;
   assign sel_enable  = (state != BOOT);

   pc_next_sel #(
      .XLEN     (XLEN),
      .TRAP_VEC (TRAP_VEC)
   ) u_next_sel (
      .enable         (sel_enable),
      .cur_pc         (fetch_pc),
      .trap_valid     (trap_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .accept         (accept),
      .fetch_is_rvc   (fetch_is_rvc),
      .next_pc        (next_pc),
      .misalign       (next_misalign)
   );

   // Halt waits for the outstanding request to be taken by imem; a trap wakes HALT.
   always_comb begin
      state_next = state;
      unique case (state)
         BOOT: state_next = RUN;
         RUN: begin
            if (halt_req && (fetch_ready || !fetch_valid)) begin
               state_next = HALT;
            end
         end
         HALT: begin
            if (trap_valid || resume) begin
               state_next = RUN;
            end
         end
         default: state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         fetch_pc     <= RESET_VEC;
         fetch_seq    <= '0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_next;
         fetch_pc     <= next_pc;
         fetch_seq    <= fetch_seq + SEQ_W'(accept);
         misalign_err <= next_misalign;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model. Honours COMPRESSED_EN.
module tb_pc_gen;

   localparam int SEQ_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             trap_valid;
   logic             halt_req;
   logic             resume;
   logic             fetch_ready;
   logic             fetch_is_rvc;
   logic             fetch_valid;
   logic [31:0]      fetch_pc;
   logic [SEQ_W-1:0] fetch_seq;
   logic             misalign_err;
   logic             halted;

   int pass_cnt  = 0;
   int check_cnt = 0;

   // Behavioural model state
   bit          m_boot;
   bit          m_valid;
   bit          m_halted;
   logic [31:0] m_pc;
   int          m_seq;
   bit          m_mis;

   pc_gen dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_valid     (trap_valid),
      .halt_req       (halt_req),
      .resume         (resume),
      .fetch_ready    (fetch_ready),
      .fetch_is_rvc   (fetch_is_rvc),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .fetch_seq      (fetch_seq),
      .misalign_err   (misalign_err),
      .halted         (halted)
   );

   always #5 clk = ~clk;

`ifdef COMPRESSED_EN
   localparam int ALIGN = 2;
`else
   localparam int ALIGN = 4;
`endif

   task automatic set_idle();
      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      trap_valid     = 1'b0;
      halt_req       = 1'b0;
      resume         = 1'b0;
      fetch_ready    = 1'b0;
      fetch_is_rvc   = 1'b0;
   endtask

   // Advance the model by one clock from the current inputs, then clock the DUT.
   task automatic tick();
      bit          acc;
      logic [31:0] nxt;
      if (rst) begin
         m_boot   = 1'b1;
         m_valid  = 1'b0;
         m_halted = 1'b0;
         m_pc     = 32'h0;
         m_seq    = 0;
         m_mis    = 1'b0;
      end else begin
         acc   = m_valid && fetch_ready && !stall;
         nxt   = m_pc;
         m_mis = 1'b0;
         if (!m_boot) begin
            if (trap_valid) begin
               nxt = 32'h100;
            end else if (redirect_valid) begin
               nxt   = redirect_pc - (redirect_pc % ALIGN);
               m_mis = (redirect_pc % ALIGN) != 0;
            end else if (acc) begin
`ifdef COMPRESSED_EN
               nxt = m_pc + (fetch_is_rvc ? 32'd2 : 32'd4);
`else
               nxt = m_pc + 32'd4;
`endif
            end
         end
         m_pc  = nxt;
         m_seq = (m_seq + (acc ? 1 : 0)) % (1 << SEQ_W);
         if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            if (halt_req && fetch_ready) begin
               m_valid  = 1'b0;
               m_halted = 1'b1;
            end
         end else if (m_halted) begin
            if (trap_valid || resume) begin
               m_halted = 1'b0;
               m_valid  = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      check_cnt++;
      if (fetch_pc !== 32'h0) $display("[TB] FAIL reset_pc got %h want %h", fetch_pc, 32'h0);
      else pass_cnt++;
      check_cnt++;
      if (fetch_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", fetch_valid);
      else pass_cnt++;
      check_cnt++;
      if (fetch_seq !== 4'd0) $display("[TB] FAIL reset_seq got %0d want 0", fetch_seq);
      else pass_cnt++;
      check_cnt++;
      if (halted !== 1'b0 || misalign_err !== 1'b0)
         $display("[TB] FAIL reset_flags got halted=%b mis=%b want 0/0", halted, misalign_err);
      else pass_cnt++;
   endtask

   task automatic test_sequential();
      do_reset();
      fetch_ready = 1'b1;
      check_cnt++;
      if (fetch_valid !== 1'b0) $display("[TB] FAIL boot_valid got %b want 0", fetch_valid);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_cnt++;
         if (fetch_pc !== 32'(4 * i) || fetch_valid !== 1'b1 || fetch_seq !== SEQ_W'(i))
            $display("[TB] FAIL seq_pc[%0d] got pc=%h v=%b seq=%0d want pc=%h v=1 seq=%0d",
                     i, fetch_pc, fetch_valid, fetch_seq, 32'(4 * i), i);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      fetch_ready = 1'b1;
      repeat (3) tick();
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_cnt++;
         if (fetch_pc !== 32'h8 || fetch_seq !== 4'd2 || fetch_valid !== 1'b1)
            $display("[TB] FAIL hold_ready[%0d] got pc=%h seq=%0d v=%b want pc=8 seq=2 v=1",
                     i, fetch_pc, fetch_seq, fetch_valid);
         else pass_cnt++;
      end
      fetch_ready = 1'b1;
      stall       = 1'b1;
      tick();
      check_cnt++;
      if (fetch_pc !== 32'h8 || fetch_seq !== 4'd2)
         $display("[TB] FAIL hold_stall got pc=%h seq=%0d want pc=8 seq=2", fetch_pc, fetch_seq);
      else pass_cnt++;
      stall = 1'b0;
      tick();
      check_cnt++;
      if (fetch_pc !== 32'hC || fetch_seq !== 4'd3)
         $display("[TB] FAIL release got pc=%h seq=%0d want pc=c seq=3", fetch_pc, fetch_seq);
      else pass_cnt++;
   endtask

   task automatic test_redirect_misalign();
      logic [31:0] exp_pc;
      logic        exp_mis;
`ifdef COMPRESSED_EN
      exp_pc  = 32'h46;
      exp_mis = 1'b0;
`else
      exp_pc  = 32'h44;
      exp_mis = 1'b1;
`endif
      stall          = 1'b1;
      fetch_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h46;
      tick();
      redirect_valid = 1'b0;
      check_cnt++;
      if (fetch_pc !== exp_pc || misalign_err !== exp_mis)
         $display("[TB] FAIL redirect_46 got pc=%h mis=%b want pc=%h mis=%b",
                  fetch_pc, misalign_err, exp_pc, exp_mis);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (misalign_err !== 1'b0 || fetch_pc !== exp_pc)
         $display("[TB] FAIL mis_pulse got pc=%h mis=%b want pc=%h mis=0", fetch_pc, misalign_err, exp_pc);
      else pass_cnt++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h81;
      tick();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      check_cnt++;
      if (fetch_pc !== 32'h80 || misalign_err !== 1'b1)
         $display("[TB] FAIL redirect_81 got pc=%h mis=%b want pc=80 mis=1", fetch_pc, misalign_err);
      else pass_cnt++;
   endtask

   task automatic test_trap_priority();
      trap_valid     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      fetch_ready    = 1'b1;
      tick();
      trap_valid     = 1'b0;
      redirect_valid = 1'b0;
      check_cnt++;
      if (fetch_pc !== 32'h100 || misalign_err !== 1'b0)
         $display("[TB] FAIL trap_prio got pc=%h mis=%b want pc=100 mis=0", fetch_pc, misalign_err);
      else pass_cnt++;
   endtask

   task automatic test_halt_resume();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      fetch_ready    = 1'b1;
      tick();
      redirect_valid = 1'b0;
      halt_req       = 1'b1;
      tick();
      halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_cnt++;
         if (halted !== 1'b1 || fetch_valid !== 1'b0 || fetch_pc !== 32'h24)
            $display("[TB] FAIL halt[%0d] got h=%b v=%b pc=%h want h=1 v=0 pc=24",
                     i, halted, fetch_valid, fetch_pc);
         else pass_cnt++;
         tick();
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check_cnt++;
      if (halted !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 32'h24)
         $display("[TB] FAIL resume got h=%b v=%b pc=%h want h=0 v=1 pc=24", halted, fetch_valid, fetch_pc);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (fetch_pc !== 32'h28) $display("[TB] FAIL after_resume got pc=%h want 28", fetch_pc);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      fetch_ready    = 1'b0;
      tick();
      redirect_valid = 1'b0;
      fetch_ready    = 1'b1;
      tick();
      check_cnt++;
      if (fetch_pc !== 32'h0 || misalign_err !== 1'b0)
         $display("[TB] FAIL pc_wrap got pc=%h mis=%b want pc=0 mis=0", fetch_pc, misalign_err);
      else pass_cnt++;
      do_reset();
      fetch_ready = 1'b1;
      tick();
      repeat (15) tick();
      check_cnt++;
      if (fetch_seq !== 4'd15) $display("[TB] FAIL seq_15 got %0d want 15", fetch_seq);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (fetch_seq !== 4'd0 || fetch_pc !== 32'h40)
         $display("[TB] FAIL seq_wrap got seq=%0d pc=%h want seq=0 pc=40", fetch_seq, fetch_pc);
      else pass_cnt++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst            = ($urandom_range(99) == 0);
         trap_valid     = ($urandom_range(15) == 0);
         redirect_valid = ($urandom_range(7) == 0);
         redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3)) : $urandom;
         halt_req       = ($urandom_range(9) == 0);
         resume         = ($urandom_range(3) == 0);
         fetch_ready    = ($urandom_range(3) != 0);
         stall          = ($urandom_range(4) == 0);
         fetch_is_rvc   = $urandom_range(1) == 1;
         tick();
         check_cnt++;
         if (fetch_pc !== m_pc)
            $display("[TB] FAIL rand_pc[%0d] got %h want %h", i, fetch_pc, m_pc);
         else pass_cnt++;
         check_cnt++;
         if (fetch_seq !== SEQ_W'(m_seq))
            $display("[TB] FAIL rand_seq[%0d] got %0d want %0d", i, fetch_seq, m_seq);
         else pass_cnt++;
         check_cnt++;
         if (fetch_valid !== m_valid || halted !== m_halted || misalign_err !== m_mis)
            $display("[TB] FAIL rand_flags[%0d] got v=%b h=%b mis=%b want v=%b h=%b mis=%b",
                     i, fetch_valid, halted, misalign_err, m_valid, m_halted, m_mis);
         else pass_cnt++;
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      $display("[TB] starting pc_gen bench");
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_misalign();
      test_trap_priority();
      test_halt_resume();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
